pll_lock_ctrl: RTL and testbench
================================

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: refclk cycles pll_rst is held per reset attempt (range 1..255).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: refclk cycles allowed from pll_rst release to lock (1 ms at 50 MHz; range 1..2^20-1).
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: refclk cycles lock must hold continuously before release of sys_rst (range 1..2^16-1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: consecutive failed lock attempts before the FAIL state (range 1..15).
REQ-005 SHALL have port refclk, input, 1: the only clock; 50 MHz board reference, also fed to the PLL.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port locked, input, 1: PLL lock indication; asynchronous to refclk.
REQ-008 SHALL have port pll_rst, output, 1: drives the PLL reset input; active-high.
REQ-009 SHALL have port sys_rst, output, 1: active-high reset for downstream logic; high unless in state RUN.
REQ-010 SHALL have port ready, output, 1: high only in state RUN.
REQ-011 SHALL have port fail, output, 1: high only in state FAIL.
REQ-012 SHALL have port retry_cnt, output, 4: consecutive failed attempts in the current sequence.

Function
REQ-013 SHALL synchronise locked through two refclk flops; all decisions use the second flop (locked_s), adding 2 cycles of latency.
REQ-014 SHALL implement a state machine with states PLL_RESET, WAIT_LOCK, STABLE, RUN and FAIL.
REQ-015 PLL_RESET SHALL drive pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
REQ-016 WAIT_LOCK SHALL drive pll_rst=0 and behave as follows:
- locked_s=1: go to STABLE.
- Counter reaches LOCK_TIMEOUT with locked_s=0: increment retry_cnt; go to FAIL if the new value equals MAX_RETRIES, else go to PLL_RESET.
REQ-017 STABLE SHALL count consecutive locked_s=1 cycles and behave as follows:
- locked_s=0: return to WAIT_LOCK with the timeout counter restarted; retry_cnt unchanged.
- Count reaches STABLE_CYCLES: go to RUN and clear retry_cnt.
REQ-018 RUN SHALL hold sys_rst=0 and ready=1; on locked_s=0 for one cycle it SHALL go to PLL_RESET, and sys_rst SHALL be 1 from the next cycle.
REQ-019 FAIL SHALL be terminal: pll_rst=1, sys_rst=1, fail=1, retry_cnt=MAX_RETRIES; only rst leaves it.
REQ-020 If a timeout and a lock rise occur in the same cycle, lock SHALL win (go to STABLE).
REQ-021 All outputs SHALL be registered; each state's output values appear in the first cycle that state is occupied.
REQ-022 The counter SHALL be one shared 20-bit counter, cleared on every state transition.

Reset
REQ-023 While rst=1 (asynchronous, any state, including mid-sequence):
- state=PLL_RESET, counter=0, retry_cnt=0;
- pll_rst=1, sys_rst=1, ready=0, fail=0;
- synchroniser flops=0.
REQ-024 After rst falls, pll_rst SHALL remain 1 for RST_CYCLES cycles.

Configuration
REQ-025 With macro PLL_LOCK_CTRL_LOSS_CNT_EN defined, the block SHALL add output loss_cnt[7:0]:
- increments on each RUN-to-PLL_RESET transition;
- saturates at 255;
- cleared only by rst.
Without the macro, the port and its logic SHALL be absent.

Verification
REQ-026 rst pulse; locked rises 10 cycles after pll_rst falls -> pll_rst high 16 cycles, STABLE entered 2 cycles after the rise, sys_rst falls 1024 cycles later, ready=1, retry_cnt=0.
REQ-027 locked held 0 (LOCK_TIMEOUT=100, MAX_RETRIES=3) -> three 16-cycle pll_rst pulses spaced by 100-cycle waits, then fail=1, retry_cnt=3, pll_rst stuck 1.
REQ-028 In STABLE, locked glitches low 1 cycle at count 500 -> return to WAIT_LOCK; sys_rst stays 1 until 1024 new consecutive locked cycles.
REQ-029 In RUN, locked drops -> sys_rst=1 and pll_rst=1 within 4 cycles; with the macro, loss_cnt goes 0->1; relock returns to RUN.
REQ-030 rst asserted mid-WAIT_LOCK with retry_cnt=2 -> outputs take reset values immediately (asynchronously) and retry_cnt=0.

Source files
------------

// File: rtl/pll_lock_ctrl.sv
// PLL lock controller: pulses the PLL reset, waits for a stable lock and then releases sys_rst.
// Optional loss-of-lock event counter on output loss_cnt, enabled by defining PLL_LOCK_CTRL_LOSS_CNT_EN.
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } state_t;

    localparam logic [19:0] RST_LAST     = 20'(RST_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] STABLE_LAST  = 20'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRIES);

    state_t      state;
    state_t      state_nxt;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic [3:0]  retry_nxt;
    logic        locked_m;
    logic        locked_s;

    // locked comes straight from the PLL, so it is brought into refclk before any use.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 20'd1;
        retry_nxt = retry_cnt;
        case (state)
            PLL_RESET: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock is tested first so a lock arriving on the timeout cycle still wins.
                if (locked_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry_cnt + 4'd1;
                    cnt_nxt   = '0;
                    state_nxt = (retry_nxt == RETRY_MAX) ? FAIL : PLL_RESET;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!locked_s) begin
                    state_nxt = PLL_RESET;
                end
            end
            FAIL: begin
                cnt_nxt   = '0;
                retry_nxt = RETRY_MAX;
            end
            default: begin
                state_nxt = PLL_RESET;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the first cycle in that state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= PLL_RESET;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            pll_rst   <= (state_nxt == PLL_RESET) || (state_nxt == FAIL);
            sys_rst   <= (state_nxt != RUN);
            ready     <= (state_nxt == RUN);
            fail      <= (state_nxt == FAIL);
        end
    end

`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_cnt <= '0;
        end else if ((state == RUN) && !locked_s && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench for pll_lock_ctrl: a cycle model queues expected outputs, a monitor compares them.
// Also checks key timings against fixed numbers; honours PLL_LOCK_CTRL_LOSS_CNT_EN.
module tb_pll_lock_ctrl;

    localparam int RST_CYCLES    = 16;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 1024;
    localparam int MAX_RETRIES   = 3;

    localparam int M_PR   = 0;
    localparam int M_WL   = 1;
    localparam int M_ST   = 2;
    localparam int M_RUN  = 3;
    localparam int M_FAIL = 4;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int num_vectors     = 0;
    int num_miscompares = 0;

    logic [15:0] exp_q[$];

    int   m_state;
    int   m_rem;
    int   m_retry;
    int   m_loss;
    logic m_s1;
    logic m_s2;

    pll_lock_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (locked),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .fail     (fail),
        .retry_cnt(retry_cnt)
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
        ,
        .loss_cnt (loss_cnt)
`endif
    );

    always #5 refclk = ~refclk;

    task check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        num_vectors++;
        if (actual !== expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model counts down the cycles left in each phase.
    task model_step();
        logic s2_old;
        if (rst) begin
            m_state = M_PR;
            m_rem   = RST_CYCLES;
            m_retry = 0;
            m_loss  = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
        end else begin
            s2_old = m_s2;
            m_s2   = m_s1;
            m_s1   = locked;
            case (m_state)
                M_PR: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_state = M_WL;
                        m_rem   = LOCK_TIMEOUT;
                    end
                end
                M_WL: begin
                    if (s2_old) begin
                        m_state = M_ST;
                        m_rem   = STABLE_CYCLES;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_retry++;
                            if (m_retry == MAX_RETRIES) begin
                                m_state = M_FAIL;
                            end else begin
                                m_state = M_PR;
                                m_rem   = RST_CYCLES;
                            end
                        end
                    end
                end
                M_ST: begin
                    if (!s2_old) begin
                        m_state = M_WL;
                        m_rem   = LOCK_TIMEOUT;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_state = M_RUN;
                            m_retry = 0;
                        end
                    end
                end
                M_RUN: begin
                    if (!s2_old) begin
                        m_state = M_PR;
                        m_rem   = RST_CYCLES;
                        if (m_loss < 255) m_loss++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [15:0] model_outputs();
        logic [7:0] loss;
        loss = 8'h00;
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
        loss = 8'(m_loss);
`endif
        return {loss, (m_state == M_PR) || (m_state == M_FAIL), m_state != M_RUN,
                m_state == M_RUN, m_state == M_FAIL, 4'(m_retry)};
    endfunction

    function automatic logic [15:0] dut_outputs();
        logic [7:0] loss;
        loss = 8'h00;
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
        loss = loss_cnt;
`endif
        return {loss, pll_rst, sys_rst, ready, fail, retry_cnt};
    endfunction

    // One refclk cycle: queue the expectation for the coming edge, then return just after the falling edge.
    task apply_stimulus();
        model_step();
        exp_q.push_back(model_outputs());
        @(posedge refclk);
        @(negedge refclk);
        #1;
    endtask

    initial begin
        logic [15:0] e;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("cycle_outputs", 32'(dut_outputs()), 32'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst    = 1'b1;
        locked = 1'b0;
        repeat (3) apply_stimulus();
        check_output("reset_values", {pll_rst, sys_rst, ready, fail, retry_cnt}, 8'b1100_0000);

        // Normal bring-up: lock arrives 10 cycles after the PLL reset is released.
        rst = 1'b0;
        n = 0;
        do begin apply_stimulus(); n++; end while (pll_rst && n < 200);
        check_output("pll_rst_width", n, RST_CYCLES);
        repeat (10) apply_stimulus();
        locked = 1'b1;
        n = 0;
        do begin apply_stimulus(); n++; end while (sys_rst && n < 3000);
        check_output("lock_to_run", n, STABLE_CYCLES + 3);
        check_output("run_ready", ready, 1);
        check_output("run_retry", retry_cnt, 0);

        // Loss of lock while running.
        locked = 1'b0;
        n = 0;
        do begin apply_stimulus(); n++; end while (!pll_rst && n < 20);
        check_output("loss_within_4", (n <= 4), 1);
        check_output("loss_sys_rst", sys_rst, 1);
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
        check_output("loss_cnt_one", loss_cnt, 1);
`endif

        // Relock, then a one-cycle glitch after 500 stable cycles restarts qualification.
        repeat (21) apply_stimulus();
        locked = 1'b1;
        repeat (503) apply_stimulus();
        check_output("glitch_pre_ready", ready, 0);
        locked = 1'b0;
        apply_stimulus();
        locked = 1'b1;
        n = 0;
        do begin apply_stimulus(); n++; end while (!ready && n < 3000);
        check_output("glitch_to_run", n, STABLE_CYCLES + 3);

        // Asynchronous reset in the middle of the third lock wait.
        locked = 1'b0;
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        repeat (2 * (RST_CYCLES + LOCK_TIMEOUT) + RST_CYCLES + 50) apply_stimulus();
        check_output("retry_two", retry_cnt, 2);
        check_output("in_wait_lock", pll_rst, 0);
        #2 rst = 1'b1;
        #1 check_output("async_reset", {pll_rst, sys_rst, ready, fail, retry_cnt}, 8'b1100_0000);
        repeat (2) apply_stimulus();

        // No lock at all: three attempts then the terminal fail state.
        rst = 1'b0;
        n = 0;
        do begin apply_stimulus(); n++; end while (!fail && n < 1000);
        check_output("time_to_fail", n, MAX_RETRIES * (RST_CYCLES + LOCK_TIMEOUT));
        check_output("fail_retry", retry_cnt, MAX_RETRIES);
        check_output("fail_pll_rst", pll_rst, 1);
        repeat (20) apply_stimulus();
        check_output("fail_sticky", {fail, pll_rst, sys_rst}, 3'b111);

        // Lock seen on the very cycle the timeout expires.
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        repeat (RST_CYCLES + LOCK_TIMEOUT - 3) apply_stimulus();
        locked = 1'b1;
        repeat (10) apply_stimulus();
        check_output("lock_beats_timeout", retry_cnt, 0);
        check_output("lock_beats_pll_rst", pll_rst, 0);

        check_output("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
